// File: rtl/shift_load_ctrl.sv
// shift_load_ctrl: upstream feeder for a WIDTH-bit parallel-load shift stage.
// Buffers words from a valid/ready producer in a DEPTH-entry FIFO and issues
// one single-cycle load per word, with consecutive loads spaced at least
// SHIFT_CYCLES cycles apart so each word is fully shifted out first.
//
// Optional feature macro: SHIFT_LOAD_FLUSH_EN adds a synchronous flush input.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   flush     (SHIFT_LOAD_FLUSH_EN only) empty FIFO, return to IDLE; d is kept
//   in_valid  producer has a word on in_data
//   in_data   word to load into the shift stage
//   in_ready  FIFO can accept a word this cycle (registered)
//   d         parallel data to the shift stage (registered)
//   load      one-cycle load strobe (registered)
//   busy      FSM not in IDLE (registered)
//   count     FIFO occupancy (registered)
module shift_load_ctrl #(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned SHIFT_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
`ifdef SHIFT_LOAD_FLUSH_EN
  input  logic                      flush,
`endif
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          d,
  output logic                      load,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = (SHIFT_CYCLES > 2) ? $clog2(SHIFT_CYCLES) : 1;
  // Cycles spent in SHIFT after the load cycle, minus the final zero cycle.
  localparam logic [SW-1:0] SPACE_INIT = SW'((SHIFT_CYCLES > 1) ? (SHIFT_CYCLES - 2) : 0);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [SW-1:0]     space;
  logic [SW-1:0]     space_nxt;
  logic              load_nxt;
  logic              pop;
  logic              push;
  logic              flush_i;
  logic [CW-1:0]     count_nxt;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [WIDTH-1:0]  mem [DEPTH];

`ifdef SHIFT_LOAD_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // Accept only against registered occupancy; a flush drops the push.
  assign push = in_valid && in_ready && !flush_i;

  // Next-state / load decision; pop happens exactly when a load is issued.
  always_comb begin
    state_nxt = state;
    space_nxt = space;
    load_nxt  = 1'b0;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          load_nxt  = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (SHIFT_CYCLES == 1) begin
          if (count != '0) begin
            pop      = 1'b1;
            load_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          space_nxt = SPACE_INIT;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (space == '0) begin
          if (count != '0) begin
            pop       = 1'b1;
            load_nxt  = 1'b1;
            state_nxt = LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          space_nxt = space - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush_i) begin
      state_nxt = IDLE;
      space_nxt = '0;
      load_nxt  = 1'b0;
      pop       = 1'b0;
    end
  end

  // Occupancy update; simultaneous push and pop cancel.
  always_comb begin
    count_nxt = count;
    if (flush_i) begin
      count_nxt = '0;
    end else if (push && !pop) begin
      count_nxt = count + 1'b1;
    end else if (pop && !push) begin
      count_nxt = count - 1'b1;
    end
  end

  // State, pointers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      space    <= '0;
      load     <= 1'b0;
      d        <= '0;
      busy     <= 1'b0;
      count    <= '0;
      in_ready <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      space    <= space_nxt;
      load     <= load_nxt;
      busy     <= (state_nxt != IDLE);
      count    <= count_nxt;
      in_ready <= (count_nxt < CW'(DEPTH));
      if (pop) begin
        d      <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end
    end
  end

  // FIFO storage; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

endmodule

// File: tb/tb_shift_load_ctrl.sv
// Bench for shift_load_ctrl: table vectors, directed corner sequences and
// randomized traffic against a queue-based model of the load rules
// (a buffered word is loaded as soon as spacing since the last load allows).
module tb_shift_load_ctrl;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SC    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic [WIDTH-1:0] d;
  logic             load;
  logic             busy;
  logic [2:0]       count;

  logic             in_valid1 = 1'b0;
  logic [WIDTH-1:0] in_data1 = '0;
  logic             in_ready1;
  logic [WIDTH-1:0] d1;
  logic             load1;
  logic             busy1;
  logic [2:0]       count1;

  shift_load_ctrl dut (
    .clk(clk), .rst_n(rst_n),
`ifdef SHIFT_LOAD_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .d(d), .load(load), .busy(busy), .count(count)
  );

  shift_load_ctrl #(.SHIFT_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef SHIFT_LOAD_FLUSH_EN
    .flush(1'b0),
`endif
    .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
    .d(d1), .load(load1), .busy(busy1), .count(count1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [3:0] data;
    logic       e_load;
    logic [3:0] e_d;
    logic       e_busy;
    int         e_count;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [3:0] q[$];
  logic [3:0] obs[$];
  logic       m_load = 1'b0;
  logic [3:0] m_d = '0;
  int         last = -1000;
  int         cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit exp_busy();
    return (cyc >= last) && ((cyc - last) < int'(SC));
  endfunction

  task automatic model_reset();
    q.delete();
    m_load = 1'b0;
    m_d    = '0;
    last   = -1000;
  endtask

  // One cycle: compare outputs at the falling edge, then advance the model.
  task automatic step(input bit has_row, input vec_t r);
    bit acc;
    bit pop_ok;
    @(negedge clk);
    chk("load", 32'(load), 32'(m_load));
    chk("d", 32'(d), 32'(m_d));
    chk("count", 32'(count), 32'(q.size()));
    chk("in_ready", 32'(in_ready), 32'(q.size() < int'(DEPTH)));
    chk("busy", 32'(busy), 32'(exp_busy()));
    if (has_row) begin
      chk("tbl_load", 32'(load), 32'(r.e_load));
      chk("tbl_d", 32'(d), 32'(r.e_d));
      chk("tbl_busy", 32'(busy), 32'(r.e_busy));
      chk("tbl_count", 32'(count), 32'(r.e_count));
    end
    if (load) obs.push_back(d);
    acc    = in_valid && (q.size() < int'(DEPTH));
    pop_ok = (q.size() > 0) && ((cyc + 1 - last) >= int'(SC));
`ifdef SHIFT_LOAD_FLUSH_EN
    if (flush) begin
      q.delete();
      m_load = 1'b0;
      last   = -1000;
      acc    = 1'b0;
      pop_ok = 1'b0;
    end
`endif
    if (pop_ok) begin
      m_d    = q.pop_front();
      m_load = 1'b1;
      last   = cyc + 1;
    end else begin
      m_load = 1'b0;
    end
    if (acc) q.push_back(in_data);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick();
    vec_t z;
    z = '{default: 0};
    step(1'b0, z);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  vec_t       tbl[18];
  logic [3:0] w5[5];
  logic [3:0] w4[4];

  initial begin
    int  idx;
    bit  will_acc;
    bit  seen_full;
    int  dens;

    // Hand-derived: single word, then 1010/1111 back-to-back (SHIFT_CYCLES=4)
    tbl[0]  = '{1'b1, 4'hA, 1'b0, 4'h0, 1'b0, 0};
    tbl[1]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1};
    tbl[2]  = '{1'b0, 4'h0, 1'b1, 4'hA, 1'b1, 0};
    tbl[3]  = '{1'b0, 4'h0, 1'b0, 4'hA, 1'b1, 0};
    tbl[4]  = '{1'b0, 4'h0, 1'b0, 4'hA, 1'b1, 0};
    tbl[5]  = '{1'b0, 4'h0, 1'b0, 4'hA, 1'b1, 0};
    tbl[6]  = '{1'b0, 4'h0, 1'b0, 4'hA, 1'b0, 0};
    tbl[7]  = '{1'b1, 4'hA, 1'b0, 4'hA, 1'b0, 0};
    tbl[8]  = '{1'b1, 4'hF, 1'b0, 4'hA, 1'b0, 1};
    tbl[9]  = '{1'b0, 4'h0, 1'b1, 4'hA, 1'b1, 1};
    tbl[10] = '{1'b0, 4'h0, 1'b0, 4'hA, 1'b1, 1};
    tbl[11] = '{1'b0, 4'h0, 1'b0, 4'hA, 1'b1, 1};
    tbl[12] = '{1'b0, 4'h0, 1'b0, 4'hA, 1'b1, 1};
    tbl[13] = '{1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 0};
    tbl[14] = '{1'b0, 4'h0, 1'b0, 4'hF, 1'b1, 0};
    tbl[15] = '{1'b0, 4'h0, 1'b0, 4'hF, 1'b1, 0};
    tbl[16] = '{1'b0, 4'h0, 1'b0, 4'hF, 1'b1, 0};
    tbl[17] = '{1'b0, 4'h0, 1'b0, 4'hF, 1'b0, 0};
    w5 = '{4'h3, 4'h5, 4'h9, 4'hC, 4'h6};
    w4 = '{4'h7, 4'h2, 4'hE, 4'h4};

    // Reset values
    #7;
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_sc1_ready", 32'(in_ready1), 32'd1);
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table vectors
    for (int i = 0; i < 18; i++) begin
      in_valid = tbl[i].v;
      in_data  = tbl[i].data;
      step(1'b1, tbl[i]);
    end

    // Five words with a full FIFO; producer holds the fifth until accepted
    obs.delete();
    idx = 0;
    seen_full = 1'b0;
    for (int i = 0; i < 40; i++) begin
      in_valid = (idx < 5);
      in_data  = (idx < 5) ? w5[idx] : 4'h0;
      will_acc = in_valid && (q.size() < int'(DEPTH));
      tick();
      if (will_acc) idx++;
      if (!in_ready) seen_full = 1'b1;
    end
    chk("ready_drop", 32'(seen_full), 32'd1);
    chk("five_loads", 32'(obs.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < obs.size()) chk("load_order", 32'(obs[i]), 32'(w5[i]));
    end

    // SHIFT_CYCLES=1 instance: three back-to-back loads
    in_valid1 = 1'b1; in_data1 = 4'h1; tick();
    chk("sc1_count_b", 32'(count1), 32'd1);
    chk("sc1_load_b", 32'(load1), 32'd0);
    in_data1 = 4'h2; tick();
    chk("sc1_load_c", 32'(load1), 32'd1);
    chk("sc1_d_c", 32'(d1), 32'h1);
    in_data1 = 4'h3; tick();
    chk("sc1_load_d", 32'(load1), 32'd1);
    chk("sc1_d_d", 32'(d1), 32'h2);
    in_valid1 = 1'b0; tick();
    chk("sc1_load_e", 32'(load1), 32'd1);
    chk("sc1_d_e", 32'(d1), 32'h3);
    chk("sc1_count_e", 32'(count1), 32'd0);
    chk("sc1_busy_e", 32'(busy1), 32'd1);
    tick();
    chk("sc1_load_f", 32'(load1), 32'd0);
    chk("sc1_busy_f", 32'(busy1), 32'd0);
    chk("sc1_d_f", 32'(d1), 32'h3);

    // Asynchronous reset while in SHIFT with two words buffered
    idle(6);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 4'(4'h8 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd2);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_load", 32'(load), 32'd0);
    chk("arst_d", 32'(d), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    model_reset();
    #1 rst_n = 1'b1;
    idle(8);

    // Randomized traffic with varying offered load
    dens = 50;
    for (int i = 0; i < 400; i++) begin
      if ((i % 50) == 0) dens = (i % 150 == 0) ? 20 : ((i % 100 == 0) ? 90 : 55);
      in_valid = ($urandom_range(0, 99) < dens);
      in_data  = 4'($urandom);
      tick();
    end
    idle(12);

`ifdef SHIFT_LOAD_FLUSH_EN
    // Flush with three words buffered while in SHIFT
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = w4[i];
      tick();
    end
    in_valid = 1'b0;
    chk("pre_flush_count", 32'(count), 32'd3);
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 4'hB;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_d", 32'(d), 32'(w4[0]));
    idle(8);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_load_ctrl.md
Name: shift_load_ctrl

Overview:
Upstream feeder for the 4-bit parallel-load shift stage. It accepts nibbles over a valid/ready handshake and buffers them in a small FIFO. It then drives the shift stage's d and load inputs, issuing one single-cycle load per word. Consecutive loads are spaced so that each word is fully shifted out before the next one overwrites it.

Parameters:
WIDTH, 4, data width of in_data and d; matches the shift stage width.
DEPTH, 4, FIFO entries; power of two, minimum 2.
SHIFT_CYCLES, 4, minimum cycles from one load pulse to the next (load high in cycle k, next load no earlier than cycle k+SHIFT_CYCLES); minimum 1.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer has a word on in_data
in_data  input  WIDTH  word to be loaded into the shift stage
in_ready  output  1  FIFO can accept a word this cycle
d  output  WIDTH  parallel data to the shift stage; registered
load  output  1  one-cycle load strobe to the shift stage; registered
busy  output  1  FSM not in IDLE
count  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous release on clk):
  - d=0, load=0, busy=0, count=0, in_ready=1.
  - FSM goes to IDLE; FIFO pointers go to 0; spacing counter goes to 0.
  - Reset mid-operation discards all buffered words and any in-progress spacing.
- Input handshake:
  - A word is accepted on the rising edge where in_valid && in_ready.
  - in_ready = (count < DEPTH), derived from registered state only; it does not depend on the same-cycle pop.
  - When full, in_valid is ignored and the word is not stored; the producer must hold it.
  - in_data is sampled only when accepted.
- FIFO:
  - Circular buffer; read and write pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - Order is strictly FIFO.
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE: if count>0 at the edge, pop the head into d, set load=1, go to LOAD. Otherwise stay; load=0.
  - LOAD (load=1 for exactly this cycle):
    - If SHIFT_CYCLES=1 and count>0: pop the next word into d, keep load=1, stay in LOAD (back-to-back loads).
    - Else if SHIFT_CYCLES=1: go to IDLE.
    - Else: set load=0, load the spacing counter with SHIFT_CYCLES-2, go to SHIFT.
  - SHIFT: load=0; decrement the counter each cycle. When the counter is 0:
    - if count>0, pop into d with load=1 and go to LOAD;
    - else go to IDLE.
- Latency: a word accepted at edge E0 into an empty FIFO with the FSM in IDLE gives load=1 and d=word in the cycle after edge E1.
- Back-to-back words are spaced by exactly SHIFT_CYCLES cycles between load rising edges.
- d holds its last loaded value until the next pop; it is not cleared when returning to IDLE.
- A word pushed into an empty FIFO in the same cycle the FSM would pop is not visible until the next edge; there is no bypass path.
- busy=1 in LOAD and SHIFT.

Optional Feature:
SHIFT_LOAD_FLUSH_EN
- Defined: adds input port flush (1 bit, synchronous, active-high). On an edge with flush=1:
  - FIFO is emptied (count=0) and any same-cycle push is dropped;
  - FSM goes to IDLE, load=0, spacing counter=0;
  - d keeps its value.
  - flush has priority over push, pop and FSM transitions.
- Not defined: no flush port exists; the only way to empty the FIFO is draining or reset.

Test Plan:
- Reset, then push 4'b1010 once -> load high for exactly one cycle, d=1010 one cycle after acceptance; busy high for 4 cycles, then low; count returns to 0.
- Push 1010 then 1111 on consecutive cycles (SHIFT_CYCLES=4) -> load pulses exactly 4 cycles apart with d=1010 then 1111; load=0 in between.
- Push 5 words with the FSM stalled on the first load (DEPTH=4) -> in_ready drops when count=4; the held 5th word is accepted after the next pop; all 5 loads appear in order.
- SHIFT_CYCLES=1, push 0001, 0010, 0011 back-to-back -> load stays high 3 consecutive cycles with d=0001, 0010, 0011.
- Assert rst_n low while in SHIFT with 2 words buffered -> load, d, count go to 0 immediately; after release no load occurs until a new push.
- With SHIFT_LOAD_FLUSH_EN, flush while count=3 in SHIFT -> count=0 and busy=0 next cycle, no further load, d unchanged.
